// File: rtl/timer_arbiter_if.sv
// Bundle of requester and shared-timer signals around timer_arbiter.
// The arbiter uses the slave modport; the environment driving requests and the timer uses master.
interface timer_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int TICK_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*TICK_W-1:0] ticks;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic                    busy;
    logic                    tmr_start;
    logic                    tmr_timeout;

    modport master (
        output req, ticks, tmr_timeout,
        input  grant, done, busy, tmr_start
    );

    modport slave (
        input  req, ticks, tmr_timeout,
        output grant, done, busy, tmr_start
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin scheduler sharing one fixed-period timer among N_REQ requesters;
// each owner gets `ticks` timer periods, then a one-cycle done pulse.
module timer_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TICK_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    timer_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [TICK_W-1:0] remaining_q, remaining_d;
    logic [N_REQ-1:0]  grant_q, grant_d;

    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [TICK_W-1:0] pick_ticks;
    int unsigned       idx;
    logic [IDX_W-1:0]  owner_inc;
    logic              owner_req;
    logic [N_REQ-1:0]  done_w;

    // First requester at or after rr_ptr, wrapping at N_REQ-1 -> 0.
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        pick_ticks = '0;
        idx        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (pick == IDX_W'(k)) pick_ticks = bus.ticks[k*TICK_W +: TICK_W];
        end
    end

    assign owner_inc = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_req = bus.req[owner_q];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        grant_d     = grant_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d       = pick;
                    remaining_d   = pick_ticks;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    state_d       = (pick_ticks != '0) ? S_START : S_DONE;
                end
            end
            S_START: begin
                if (!owner_req) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = owner_inc;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A dropped request wins over a coincident timeout.
                if (!owner_req) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = owner_inc;
                end else if (bus.tmr_timeout) begin
                    if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
                    state_d = (remaining_q <= TICK_W'(1)) ? S_DONE : S_START;
                end
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                rr_ptr_d = owner_inc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            grant_q     <= grant_d;
        end
    end

    always_comb begin
        done_w = '0;
        if (state_q == S_DONE) done_w[owner_q] = 1'b1;
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_w;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.tmr_start = (state_q == S_START);
endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a job-level model.
module tb_timer_arbiter;
    localparam int N  = 4;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_arbiter_if #(.N_REQ(N), .TICK_W(TW)) bus ();

    timer_arbiter #(.N_REQ(N), .TICK_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Job-level reference: who owns the timer, how many periods are left,
    // whether a restart is owed and whether the job is finishing.
    bit m_busy, m_fin, m_need;
    int m_owner, m_left, m_rr;

    int tmr_cnt = -1;
    int P       = 0;
    int cyc     = 0;
    int to_cyc  = -100;

    typedef struct {
        bit                rst;
        logic [N-1:0]      req;
        logic [N*TW-1:0]   ticks;
        bit                to;
        logic [N-1:0]      g;
        logic [N-1:0]      d;
        bit                b;
        bit                s;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [N*TW-1:0] tk4(input int t3, input int t2, input int t1, input int t0);
        return {8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    function automatic vec_t mk(input bit r, input logic [N-1:0] rq, input logic [N*TW-1:0] tk,
                                input bit to, input logic [N-1:0] g, input logic [N-1:0] d,
                                input bit b, input bit s);
        vec_t v;
        v.rst = r; v.req = rq; v.ticks = tk; v.to = to;
        v.g = g; v.d = d; v.b = b; v.s = s;
        return v;
    endfunction

    function automatic int winner(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N*TW-1:0] tk, input bit to);
        int w;
        if (r) begin
            m_busy = 0; m_fin = 0; m_need = 0; m_rr = 0; m_owner = 0; m_left = 0;
        end else if (!m_busy) begin
            w = winner(rq);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_left  = int'(tk[w*TW +: TW]);
                m_fin   = (m_left == 0);
                m_need  = (m_left != 0);
            end
        end else if (m_fin) begin
            m_busy = 0; m_fin = 0; m_rr = (m_owner + 1) % N;
        end else if (!rq[m_owner]) begin
            m_busy = 0; m_need = 0; m_rr = (m_owner + 1) % N;
        end else if (m_need) begin
            m_need = 0;
        end else if (to) begin
            m_left = m_left - 1;
            if (m_left == 0) m_fin = 1;
            else m_need = 1;
        end
    endtask

    // One clock with the timer model driving tmr_timeout; outputs checked against the model.
    task automatic sim_cycle(input bit stray);
        bit tov;
        logic [N-1:0] eg, ed;
        tov = 0;
        if (tmr_cnt > 0) begin
            tmr_cnt--;
            if (tmr_cnt == 0) begin
                tov = 1;
                tmr_cnt = -1;
            end
        end
        if (stray) tov = 1;
        bus.tmr_timeout = tov;
        if (tov) to_cyc = cyc;
        @(posedge clk);
        cyc++;
        model_step(rst, bus.req, bus.ticks, tov);
        #1;
        eg = '0; ed = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        if (m_busy && m_fin) ed[m_owner] = 1'b1;
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("done", 32'(bus.done), 32'(ed));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("tmr_start", 32'(bus.tmr_start), 32'(m_busy && m_need && !m_fin));
        if (bus.tmr_start) tmr_cnt = P + 1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        bus.req = '0;
        bus.ticks = '0;
        tmr_cnt = -1;
        sim_cycle(0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int starts, grant_bad, done_cycles, done_at;
        logic [N-1:0] done_val, reraise, prev_grant;
        int order[$];
        bit seen;

        rst = 1'b1;
        bus.req = '0;
        bus.ticks = '0;
        bus.tmr_timeout = 1'b0;

        // rst, req, ticks, to | grant, done, busy, tmr_start
        tbl.push_back(mk(1, 4'b0000, tk4(0,0,0,0), 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0100, tk4(0,0,0,0), 0, 4'b0100, 4'b0100, 1, 0));
        tbl.push_back(mk(0, 4'b0000, tk4(0,0,0,0), 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1001, tk4(2,0,0,1), 0, 4'b1000, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b1001, tk4(2,0,0,1), 0, 4'b1000, 4'b0000, 1, 0));
        tbl.push_back(mk(1, 4'b1001, tk4(2,0,0,1), 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1010, tk4(1,0,1,0), 0, 4'b0010, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b1010, tk4(1,0,1,0), 0, 4'b0010, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b1010, tk4(1,0,1,0), 1, 4'b0010, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 4'b1000, tk4(1,0,1,0), 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1000, tk4(1,0,1,0), 0, 4'b1000, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b1000, tk4(1,0,1,0), 0, 4'b1000, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, tk4(1,0,1,0), 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0000, tk4(1,0,1,0), 1, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0010, tk4(0,0,5,0), 0, 4'b0010, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b0010, tk4(0,0,5,0), 0, 4'b0010, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0010, tk4(0,0,5,0), 1, 4'b0010, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b0010, tk4(0,0,5,0), 0, 4'b0010, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, tk4(0,0,5,0), 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0000, tk4(0,0,5,0), 1, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0011, tk4(0,0,1,0), 0, 4'b0001, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0010, tk4(0,0,1,0), 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0010, tk4(0,0,1,0), 0, 4'b0010, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 4'b0010, tk4(0,0,1,0), 0, 4'b0010, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 4'b0000, tk4(0,0,1,0), 1, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0000, tk4(0,0,1,0), 0, 4'b0000, 4'b0000, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            bus.req = tbl[i].req;
            bus.ticks = tbl[i].ticks;
            bus.tmr_timeout = tbl[i].to;
            @(posedge clk);
            cyc++;
            #1;
            chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(tbl[i].d));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].b));
            chk($sformatf("vec%0d_tmr_start", i), 32'(bus.tmr_start), 32'(tbl[i].s));
        end
        bus.tmr_timeout = 1'b0;

        // Single request: 3 periods of a P=10 timer.
        P = 10;
        reset_all();
        bus.req = 4'b0001;
        bus.ticks = tk4(0,0,0,3);
        starts = 0; grant_bad = 0; done_cycles = 0; done_at = -1; done_val = '0;
        for (int k = 0; k < 200 && done_cycles == 0; k++) begin
            sim_cycle(0);
            if (bus.tmr_start) starts++;
            if (bus.busy && bus.grant != 4'b0001) grant_bad++;
            if (bus.done != '0) begin
                done_cycles++;
                done_at = cyc;
                done_val = bus.done;
                bus.req = '0;
            end
        end
        chk("single_done_seen", 32'(done_cycles), 32'd1);
        chk("single_done_after_timeout", 32'(done_at - to_cyc), 32'd1);
        for (int k = 0; k < 4; k++) begin
            sim_cycle(0);
            if (bus.done != '0) done_cycles++;
            if (bus.tmr_start) starts++;
        end
        chk("single_starts", 32'(starts), 32'd3);
        chk("single_done_val", 32'(done_val), 32'b0001);
        chk("single_done_width", 32'(done_cycles), 32'd1);
        chk("single_grant_bad", 32'(grant_bad), 32'd0);

        // Round-robin fairness with all requesters re-requesting after done.
        P = 2;
        reset_all();
        bus.req = 4'b1111;
        bus.ticks = tk4(1,1,1,1);
        reraise = '0;
        prev_grant = '0;
        order.delete();
        for (int k = 0; k < 400 && order.size() < 5; k++) begin
            bus.req = bus.req | reraise;
            reraise = '0;
            sim_cycle(0);
            if (bus.grant != '0 && bus.grant != prev_grant)
                for (int i = 0; i < N; i++) if (bus.grant[i]) order.push_back(i);
            prev_grant = bus.grant;
            if (bus.done != '0) begin
                bus.req = bus.req & ~bus.done;
                reraise = bus.done;
            end
        end
        chk("rr_grant_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % N));

        // Randomized traffic: requests, aborts, stray timeouts, occasional reset.
        reset_all();
        seen = 0;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.req[i] = 1'b1;
                        bus.ticks[i*TW +: TW] = 8'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            P = $urandom_range(0, 3);
            sim_cycle((tmr_cnt < 0) && ($urandom_range(0, 19) == 0));
            if (bus.done != '0) begin
                bus.req = bus.req & ~bus.done;
                seen = 1;
            end
        end
        chk("random_saw_done", 32'(seen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
